nf_ahb_tmr: RTL and testbench
=============================

// Module: nf_ahb_tmr
// PURPOSE
//  AHB-Lite slave timer/compare peripheral on interconnect slave port 4, beside RAM/GPIO/PWM/UART.
//  Takes the decoded slave-side bus from nf_ahb_top and presents five 32-bit registers to the CPU.
//  Prescaled up-counter with compare-match flag, level interrupt and toggle output.
// PARAMETERS
//  tmr_w   32   counter/compare/prescaler width, 1..32; register reads are zero-extended to 32 bits
// PORTS
//  hclk      in   1    clock
//  hresetn   in   1    reset, synchronous, active-low
//  haddr_s   in   32   AHB HADDR; bits [4:2] select the register
//  hwdata_s  in   32   AHB HWDATA (data phase)
//  hrdata_s  out  32   AHB HRDATA (data phase)
//  hwrite_s  in   1    AHB HWRITE
//  htrans_s  in   2    AHB HTRANS
//  hsize_s   in   3    AHB HSIZE (ignored; every access is a word access)
//  hburst_s  in   3    AHB HBURST (ignored)
//  hresp_s   out  2    AHB HRESP, constant 2'b00 (OKAY)
//  hready_s  out  1    AHB HREADYOUT, constant 1 (zero wait states)
//  hsel_s    in   1    AHB HSEL
//  tmr_irq   out  1    interrupt, level: STATUS.MATCH & CTRL.IRQ_EN
//  tmr_out   out  1    compare toggle output
// BEHAVIOUR
//  Clock and reset:
//   - Single clock hclk. Reset is sampled only on a hclk edge with hresetn==0.
//   - Reset clears every register and internal counter to 0, and clears the captured-transfer valid bit.
//   - Outputs after reset: hrdata_s=0, tmr_irq=0, tmr_out=0.
//  Register map (haddr_s[4:2]):
//   - 0 CTRL: [0]EN, [1]AUTO_RELOAD, [2]IRQ_EN, [3]TOGGLE_EN; bits [31:4] read 0.
//   - 1 PRESC: prescaler limit.
//   - 2 CNT: counter; a write loads it.
//   - 3 CMP: compare value.
//   - 4 STATUS: [0]MATCH; writing 1 clears it, writing 0 has no effect.
//   - 5..7: read 0; writes ignored.
//  Address phase:
//   - A transfer is valid when hsel_s==1 and htrans_s[1]==1 (NONSEQ/SEQ).
//   - On a valid transfer: register the address index, hwrite_s and a valid bit.
//   - IDLE/BUSY, or hsel_s==0: the valid bit is cleared.
//  Data phase (the cycle after the address phase):
//   - Write: hwdata_s[tmr_w-1:0] is written to the latched register at the end of that cycle.
//   - Read: hrdata_s = latched register, combinational from the latched index; hrdata_s=0 when not valid.
//   - Back-to-back transfers are supported. A read in the cycle immediately after a write to the same register returns the new value.
//  Prescaler:
//   - While EN=1: pcnt increments each cycle. When pcnt==PRESC: pcnt<=0 and tick=1 for that cycle.
//   - PRESC=0 gives a tick every cycle.
//   - EN=0: pcnt is held at 0, no ticks, CNT holds its value.
//  Counter, on each tick:
//   - Match: if CNT==CMP then MATCH<=1, tmr_out toggles when TOGGLE_EN=1, and CNT<=0 when AUTO_RELOAD=1.
//   - Otherwise: CNT<=CNT+1, wrapping modulo 2^tmr_w (all-ones -> 0) with no flag.
//   - Match with AUTO_RELOAD=0: CNT<=CNT+1.
//  Collisions:
//   - Bus write to CNT in the same cycle as a tick: the bus write wins, and that tick's match check is skipped.
//   - Bus write-1-clear of MATCH in the same cycle as a new match: set wins and MATCH stays 1.
//   - Writing PRESC below the current pcnt: pcnt runs up to its wrap point (all-ones -> 0) and then counts to the new PRESC; no reset.
//  tmr_irq is combinational from registers, with no extra latency.
// TESTING
//  - Reset: drive hresetn=0 during an active counter -> next edge CNT=0, tmr_irq=0, tmr_out=0, hrdata_s=0.
//  - Bus: write CMP=0x1234 then read CMP back-to-back -> hrdata_s=0x1234 in the read data phase; read index 6 -> 0.
//  - Prescaler: PRESC=3, CNT=0, CMP=0xFFFF, CTRL=0x1 -> CNT=1 after 4 cycles, CNT=5 after 20 cycles.
//  - Match/reload: PRESC=0, CMP=4, CTRL=0xF:
//     - CNT sequence 0..4,0,1..; MATCH=1 and tmr_irq=1 from the match tick.
//     - tmr_out toggles on every 5th tick.
//  - W1C race: write STATUS=1 in the same cycle as a match tick -> MATCH stays 1; a later clear with no match -> 0.
//  - Wrap/collision (tmr_w=8):
//     - CNT=0xFF, CMP=0x10, tick -> CNT=0x00, MATCH=0.
//     - A CNT write of 0x42 coinciding with a tick -> CNT=0x42.

Source files
------------

// File: rtl/nf_ahb_tmr.sv
// nf_ahb_tmr: AHB-Lite timer/compare slave with a prescaled up-counter,
// a sticky compare-match flag, a level interrupt and a compare toggle output.
//
// Ports:
//   hclk, hresetn     clock; synchronous active-low reset
//   haddr_s           address; bits [4:2] select CTRL/PRESC/CNT/CMP/STATUS
//   hwdata_s          write data (data phase)
//   hrdata_s          read data (data phase, combinational from latched index)
//   hwrite_s          1 = write
//   htrans_s          transfer type; bit 1 marks NONSEQ/SEQ
//   hsize_s/hburst_s  accepted but unused (word accesses only)
//   hresp_s           always OKAY
//   hready_s          always ready (zero wait states)
//   hsel_s            slave select
//   tmr_irq           STATUS.MATCH & CTRL.IRQ_EN
//   tmr_out           toggles on each compare match when CTRL.TOGGLE_EN=1
module nf_ahb_tmr #(
    parameter int unsigned tmr_w = 32
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic [31:0] haddr_s,
    input  logic [31:0] hwdata_s,
    output logic [31:0] hrdata_s,
    input  logic        hwrite_s,
    input  logic [1:0]  htrans_s,
    input  logic [2:0]  hsize_s,
    input  logic [2:0]  hburst_s,
    output logic [1:0]  hresp_s,
    output logic        hready_s,
    input  logic        hsel_s,
    output logic        tmr_irq,
    output logic        tmr_out
);

    localparam int unsigned IDX_W = 3;

    localparam logic [IDX_W-1:0] IDX_CTRL   = 3'd0;
    localparam logic [IDX_W-1:0] IDX_PRESC  = 3'd1;
    localparam logic [IDX_W-1:0] IDX_CNT    = 3'd2;
    localparam logic [IDX_W-1:0] IDX_CMP    = 3'd3;
    localparam logic [IDX_W-1:0] IDX_STATUS = 3'd4;

    // Register state
    logic [3:0]       ctrl;
    logic [tmr_w-1:0] presc;
    logic [tmr_w-1:0] cnt;
    logic [tmr_w-1:0] cmp;
    logic [tmr_w-1:0] pcnt;
    logic             match;
    logic             tout;

    // Captured address phase
    logic [IDX_W-1:0] a_idx;
    logic             a_write;
    logic             a_valid;

    // Next-state values
    logic [3:0]       ctrl_nxt;
    logic [tmr_w-1:0] presc_nxt;
    logic [tmr_w-1:0] cnt_nxt;
    logic [tmr_w-1:0] cmp_nxt;
    logic [tmr_w-1:0] pcnt_nxt;
    logic             match_nxt;
    logic             tout_nxt;

    logic             wr_c;
    logic             wr_cnt_c;
    logic             tick_c;
    logic             hit_c;
    logic [tmr_w-1:0] wdata_c;

    logic             unused_bus;

    assign hresp_s  = 2'b00;
    assign hready_s = 1'b1;
    assign tmr_irq  = match & ctrl[2];
    assign tmr_out  = tout;

    // Bus bits that carry no meaning for this slave
    assign unused_bus = ^{hsize_s, hburst_s, haddr_s[31:5], haddr_s[1:0],
                          htrans_s[0], hwdata_s};

    assign wdata_c  = hwdata_s[tmr_w-1:0];
    assign wr_c     = a_valid & a_write;
    assign wr_cnt_c = wr_c && (a_idx == IDX_CNT);

    // Prescaler wraps through all-ones if PRESC is lowered below pcnt
    assign tick_c = ctrl[0] && (pcnt == presc);
    // A CNT bus write in the tick cycle suppresses that tick's compare
    assign hit_c  = tick_c && !wr_cnt_c && (cnt == cmp);

    // Next-state logic for counters and registers
    always_comb begin
        ctrl_nxt  = ctrl;
        presc_nxt = presc;
        cnt_nxt   = cnt;
        cmp_nxt   = cmp;
        pcnt_nxt  = pcnt;
        match_nxt = match;
        tout_nxt  = tout;

        if (!ctrl[0]) begin
            pcnt_nxt = '0;
        end else if (tick_c) begin
            pcnt_nxt = '0;
        end else begin
            pcnt_nxt = pcnt + tmr_w'(1);
        end

        if (wr_cnt_c) begin
            cnt_nxt = wdata_c;
        end else if (tick_c) begin
            if (hit_c && ctrl[1]) begin
                cnt_nxt = '0;
            end else begin
                cnt_nxt = cnt + tmr_w'(1);
            end
        end

        if (hit_c && ctrl[3]) begin
            tout_nxt = ~tout;
        end

        if (wr_c) begin
            case (a_idx)
                IDX_CTRL:   ctrl_nxt  = hwdata_s[3:0];
                IDX_PRESC:  presc_nxt = wdata_c;
                IDX_CMP:    cmp_nxt   = wdata_c;
                IDX_STATUS: if (hwdata_s[0]) match_nxt = 1'b0;
                default:    ;
            endcase
        end

        // A new match overrides a same-cycle clear
        if (hit_c) begin
            match_nxt = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            ctrl    <= '0;
            presc   <= '0;
            cnt     <= '0;
            cmp     <= '0;
            pcnt    <= '0;
            match   <= 1'b0;
            tout    <= 1'b0;
            a_idx   <= '0;
            a_write <= 1'b0;
            a_valid <= 1'b0;
        end else begin
            ctrl    <= ctrl_nxt;
            presc   <= presc_nxt;
            cnt     <= cnt_nxt;
            cmp     <= cmp_nxt;
            pcnt    <= pcnt_nxt;
            match   <= match_nxt;
            tout    <= tout_nxt;
            if (hsel_s && htrans_s[1]) begin
                a_idx   <= haddr_s[4:2];
                a_write <= hwrite_s;
                a_valid <= 1'b1;
            end else begin
                a_valid <= 1'b0;
            end
        end
    end

    // Data-phase read mux, zero-extended to the bus width
    always_comb begin
        hrdata_s = '0;
        if (a_valid) begin
            case (a_idx)
                IDX_CTRL:   hrdata_s = {28'b0, ctrl};
                IDX_PRESC:  hrdata_s = 32'(presc);
                IDX_CNT:    hrdata_s = 32'(cnt);
                IDX_CMP:    hrdata_s = 32'(cmp);
                IDX_STATUS: hrdata_s = {31'b0, match};
                default:    hrdata_s = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_nf_ahb_tmr.sv
// Bench for nf_ahb_tmr: a 32-bit instance (a) and an 8-bit instance (b)
// share the bus, selected by separate hsel lines. Expected counter values are
// computed in closed form from elapsed clock edges since the enabling write.
module tb_nf_ahb_tmr;

    logic        clk = 1'b0;
    logic        hresetn;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic        hsel_a;
    logic        hsel_b;

    logic [31:0] rdata_a, rdata_b;
    logic [1:0]  resp_a, resp_b;
    logic        ready_a, ready_b;
    logic        irq_a, irq_b;
    logic        out_a, out_b;

    int unsigned cyc = 0;
    int unsigned e0 = 0;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    nf_ahb_tmr #(.tmr_w(32)) dut_a (
        .hclk(clk), .hresetn(hresetn), .haddr_s(haddr), .hwdata_s(hwdata),
        .hrdata_s(rdata_a), .hwrite_s(hwrite), .htrans_s(htrans),
        .hsize_s(hsize), .hburst_s(hburst), .hresp_s(resp_a),
        .hready_s(ready_a), .hsel_s(hsel_a), .tmr_irq(irq_a), .tmr_out(out_a)
    );

    nf_ahb_tmr #(.tmr_w(8)) dut_b (
        .hclk(clk), .hresetn(hresetn), .haddr_s(haddr), .hwdata_s(hwdata),
        .hrdata_s(rdata_b), .hwrite_s(hwrite), .htrans_s(htrans),
        .hsize_s(hsize), .hburst_s(hburst), .hresp_s(resp_b),
        .hready_s(ready_b), .hsel_s(hsel_b), .tmr_irq(irq_b), .tmr_out(out_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        htrans = 2'b00;
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        hwrite = 1'b0;
    endtask

    task automatic addr_phase(input bit dut, input logic [2:0] idx, input bit wr);
        haddr  = {27'b0, idx, 2'b00};
        hwrite = wr;
        htrans = 2'b10;
        hsel_a = !dut;
        hsel_b = dut;
    endtask

    task automatic bus_write(input bit dut, input logic [2:0] idx, input logic [31:0] d);
        addr_phase(dut, idx, 1'b1);
        step();
        idle();
        hwdata = d;
        step();
    endtask

    // Returns while still in the data phase, with hrdata valid
    task automatic bus_read(input bit dut, input logic [2:0] idx, output logic [31:0] d);
        addr_phase(dut, idx, 1'b0);
        step();
        idle();
        d = dut ? rdata_b : rdata_a;
    endtask

    task automatic wait_until(input int unsigned target);
        if (cyc > target) begin
            n_total++;
            $error("FAIL sched: cycle %0d already past target %0d", cyc, target);
        end
        while (cyc < target) step();
    endtask

    // Enabling write; its data-phase edge is edge zero for the model
    task automatic start(input bit dut, input logic [31:0] c);
        bus_write(dut, 3'd0, c);
        e0 = cyc;
    endtask

    // Read so that the sample reflects state after k edges past e0
    task automatic read_at(input bit dut, input int k, input logic [2:0] idx, output logic [31:0] d);
        wait_until(e0 + k - 1);
        bus_read(dut, idx, d);
    endtask

    // Write so that its data-phase edge is edge k past e0
    task automatic write_at(input bit dut, input int k, input logic [2:0] idx, input logic [31:0] d);
        wait_until(e0 + k - 2);
        bus_write(dut, idx, d);
    endtask

    task automatic do_reset();
        hresetn = 1'b0;
        step();
        hresetn = 1'b1;
    endtask

    // Auto-reload model: ticks = k/(p+1); counter cycles through 0..c
    function automatic int m_cnt(input int p, input int c, input int k);
        return (k / (p + 1)) % (c + 1);
    endfunction

    function automatic int m_matches(input int p, input int c, input int k);
        return (k / (p + 1)) / (c + 1);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int p, c, ie, k, mt;
        hresetn = 1'b0;
        haddr = '0; hwdata = '0; hsize = 3'b010; hburst = 3'b000;
        idle();
        step();
        step();
        hresetn = 1'b1;

        // Reset state and constant responses
        check("rst_rdata", rdata_a, 32'h0);
        check("rst_irq", irq_a, 1'b0);
        check("rst_out", out_a, 1'b0);
        check("hready", ready_a, 1'b1);
        check("hresp", resp_a, 2'b00);

        // Back-to-back write then read of CMP
        addr_phase(1'b0, 3'd3, 1'b1);
        step();
        hwdata = 32'h0000_1234;
        addr_phase(1'b0, 3'd3, 1'b0);
        step();
        idle();
        check("b2b_cmp", rdata_a, 32'h0000_1234);
        bus_write(1'b0, 3'd6, 32'hFFFF_FFFF);
        bus_read(1'b0, 3'd6, d);
        check("idx6_read", d, 32'h0);
        bus_write(1'b0, 3'd0, 32'hFFFF_FFFA);
        bus_read(1'b0, 3'd0, d);
        check("ctrl_mask", d, 32'hA);
        bus_write(1'b0, 3'd0, 32'h0);

        // Prescaler: PRESC=3 gives one tick every 4 cycles
        do_reset();
        bus_write(1'b0, 3'd1, 32'd3);
        bus_write(1'b0, 3'd3, 32'hFFFF);
        bus_write(1'b0, 3'd2, 32'd0);
        start(1'b0, 32'h1);
        read_at(1'b0, 4, 3'd2, d);
        check("presc_cnt4", d, 32'd1);
        read_at(1'b0, 20, 3'd2, d);
        check("presc_cnt20", d, 32'd5);

        // Match with auto-reload, interrupt and toggle
        do_reset();
        bus_write(1'b0, 3'd1, 32'd0);
        bus_write(1'b0, 3'd3, 32'd4);
        start(1'b0, 32'hF);
        read_at(1'b0, 4, 3'd2, d);
        check("mr_cnt4", d, 32'd4);
        check("mr_irq4", irq_a, 1'b0);
        check("mr_out4", out_a, 1'b0);
        read_at(1'b0, 5, 3'd2, d);
        check("mr_cnt5", d, 32'd0);
        check("mr_irq5", irq_a, 1'b1);
        check("mr_out5", out_a, 1'b1);
        read_at(1'b0, 6, 3'd4, d);
        check("mr_status", d, 32'd1);
        read_at(1'b0, 10, 3'd2, d);
        check("mr_cnt10", d, 32'd0);
        check("mr_out10", out_a, 1'b0);
        read_at(1'b0, 16, 3'd2, d);
        check("mr_cnt16", d, 32'd1);
        check("mr_out16", out_a, 1'b1);

        // Reset while counting with irq and out asserted
        do_reset();
        check("rst2_irq", irq_a, 1'b0);
        check("rst2_out", out_a, 1'b0);
        check("rst2_rdata", rdata_a, 32'h0);
        bus_read(1'b0, 3'd2, d);
        check("rst2_cnt", d, 32'h0);

        // W1C in the same cycle as a match: set wins
        do_reset();
        bus_write(1'b0, 3'd1, 32'd0);
        bus_write(1'b0, 3'd3, 32'd4);
        start(1'b0, 32'hF);
        write_at(1'b0, 5, 3'd4, 32'd1);
        read_at(1'b0, 6, 3'd4, d);
        check("w1c_race", d, 32'd1);
        check("w1c_race_irq", irq_a, 1'b1);
        write_at(1'b0, 8, 3'd4, 32'd1);
        read_at(1'b0, 9, 3'd4, d);
        check("w1c_clear", d, 32'd0);
        check("w1c_clear_irq", irq_a, 1'b0);
        read_at(1'b0, 11, 3'd4, d);
        check("w1c_rematch", d, 32'd1);

        // Randomized prescaler/compare against the closed-form model
        for (int it = 0; it < 5; it++) begin
            do_reset();
            p  = int'($urandom_range(0, 3));
            c  = int'($urandom_range(0, 6));
            ie = int'($urandom_range(0, 1));
            bus_write(1'b0, 3'd1, 32'(p));
            bus_write(1'b0, 3'd3, 32'(c));
            start(1'b0, 32'hB | (32'(ie) << 2));
            for (int r = 0; r < 5; r++) begin
                k = int'(cyc - e0) + 1 + int'($urandom_range(0, 6));
                mt = m_matches(p, c, k);
                if (r == 4) begin
                    read_at(1'b0, k, 3'd4, d);
                    check("rnd_status", d, (mt > 0) ? 32'd1 : 32'd0);
                end else begin
                    read_at(1'b0, k, 3'd2, d);
                    check("rnd_cnt", d, 32'(m_cnt(p, c, k)));
                end
                check("rnd_out", out_a, 32'(mt % 2));
                check("rnd_irq", irq_a, (ie == 1 && mt > 0) ? 32'd1 : 32'd0);
            end
        end

        // 8-bit instance: wrap from all-ones without a match
        do_reset();
        bus_write(1'b1, 3'd2, 32'hFF);
        bus_write(1'b1, 3'd3, 32'h10);
        bus_write(1'b1, 3'd1, 32'h0);
        start(1'b1, 32'h1);
        read_at(1'b1, 1, 3'd2, d);
        check("w8_wrap", d, 32'h00);
        read_at(1'b1, 2, 3'd4, d);
        check("w8_nomatch", d, 32'h0);

        // 8-bit instance: CNT write on the would-be match tick wins
        do_reset();
        bus_write(1'b1, 3'd3, 32'h5);
        bus_write(1'b1, 3'd1, 32'h0);
        start(1'b1, 32'h1);
        write_at(1'b1, 6, 3'd2, 32'h0000_0142);
        read_at(1'b1, 7, 3'd2, d);
        check("w8_coll_cnt", d, 32'h43);
        read_at(1'b1, 8, 3'd4, d);
        check("w8_coll_match", d, 32'h0);
        check("w8_coll_irq", irq_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
